// File: rtl/pipe_gen.sv
// Scrolling pipe generator: three pipes move left on each frame tick.
// A pipe that leaves the screen respawns off the right edge with an LFSR-chosen gap.
module pipe_gen #(
    parameter int unsigned TICK_DIV = 1666667,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned PIPE_W   = 52,
    parameter int unsigned SPACING  = 240,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned BIRD_X   = 160,
    parameter int unsigned GAP_INIT = 180,
    parameter int unsigned GAP_MIN  = 40,
    parameter int unsigned SPAN     = 280
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  status,
    output logic [31:0] pipe1,
    output logic [31:0] pipe2,
    output logic [31:0] pipe3,
    output logic        pass,
    output logic        tick
);

    localparam int unsigned CW = $clog2(TICK_DIV + 1);
    localparam logic [15:0] X_BASE = 16'(SCREEN_W + PIPE_W);
    localparam logic [15:0] X_STEP = 16'(SPACING);
    localparam logic [15:0] X_WRAP = 16'(3 * SPACING);
    localparam logic [15:0] SPD    = 16'(SPEED);
    localparam logic [15:0] BX     = 16'(BIRD_X);
    localparam logic [15:0] G_INIT = 16'(GAP_INIT);
    localparam logic [15:0] G_MIN  = 16'(GAP_MIN);

    typedef enum logic [1:0] {
        S_READY,
        S_PLAY,
        S_OVER
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   lfsr;
    logic          fb;
    logic [8:0]    rnd;
    logic [15:0]   gap_new;
    logic [15:0]   x_q [3];
    logic [15:0]   g_q [3];
    logic [15:0]   x_d [3];
    logic [15:0]   g_d [3];
    logic          pass_d;

    always_comb begin
        unique case (status)
            2'b00:   state = S_READY;
            2'b01:   state = S_PLAY;
            default: state = S_OVER;
        endcase
    end

    assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign rnd     = lfsr[8:0];
    assign gap_new = G_MIN + ((rnd < 9'(SPAN)) ? 16'(rnd) : 16'(rnd) - 16'(SPAN));

    always_comb begin
        x_d    = x_q;
        g_d    = g_q;
        pass_d = 1'b0;
        unique case (state)
            S_READY: begin
                for (int i = 0; i < 3; i++) begin
                    x_d[i] = X_BASE + 16'(i) * X_STEP;
                    g_d[i] = G_INIT;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    for (int i = 0; i < 3; i++) begin
                        x_d[i] = x_q[i] - SPD;
                        // Respawn shares one LFSR sample across pipes this tick
                        if (x_q[i] <= SPD) begin
                            x_d[i] = x_q[i] - SPD + X_WRAP;
                            g_d[i] = gap_new;
                        end
                        if (x_q[i] > BX && x_q[i] - SPD <= BX)
                            pass_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
            lfsr <= 16'hACE1;
            pass <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                x_q[i] <= X_BASE + 16'(i) * X_STEP;
                g_q[i] <= G_INIT;
            end
        end else begin
            cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
            tick <= (cnt == CW'(TICK_DIV - 1));
            lfsr <= {lfsr[14:0], fb};
            pass <= pass_d;
            x_q  <= x_d;
            g_q  <= g_d;
        end
    end

    assign pipe1 = {x_q[0], g_q[0]};
    assign pipe2 = {x_q[1], g_q[1]};
    assign pipe3 = {x_q[2], g_q[2]};

endmodule

// File: tb/tb_pipe_gen.sv
// Randomized scoreboard bench for pipe_gen with a behavioural reference model.
// Directed checkpoints follow the scenario list; random status phases follow.
module tb_pipe_gen;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  status;
    logic [31:0] pipe1, pipe2, pipe3;
    logic        pass, tick;

    pipe_gen #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .status(status),
        .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3),
        .pass(pass), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p1, p2, p3;
        logic        ps, tk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_ok     = 0;

    // reference model state (values visible after the latest edge)
    int       m_x[3];
    int       m_g[3];
    bit       m_pass;
    bit       m_tick;
    int       m_t;
    bit [15:0] m_lfsr;
    int       play_ticks;

    function automatic bit [15:0] lfsr_next(bit [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(string name, longint act, longint req);
        n_checks++;
        if (act == req) n_ok++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic model_reload();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = 692 + 240 * i;
            m_g[i] = 180;
        end
    endtask

    // Apply inputs, advance the model across one edge, queue the expectation.
    task automatic cyc(input bit r, input bit [1:0] s);
        exp_t e;
        int rr;
        rst    = r;
        status = s;
        if (r) begin
            model_reload();
            m_pass = 0;
            m_tick = 0;
            m_t    = 0;
            m_lfsr = 16'hACE1;
        end else begin
            m_pass = 0;
            if (s == 2'b00) model_reload();
            else if (s == 2'b01 && m_tick) begin
                play_ticks++;
                rr = (m_lfsr[8:0] < 280) ? int'(m_lfsr[8:0]) : int'(m_lfsr[8:0]) - 280;
                for (int i = 0; i < 3; i++) begin
                    if (m_x[i] > 160 && m_x[i] - 2 <= 160) m_pass = 1;
                    if (m_x[i] <= 2) begin
                        m_x[i] = m_x[i] - 2 + 720;
                        m_g[i] = 40 + rr;
                    end else begin
                        m_x[i] = m_x[i] - 2;
                    end
                end
            end
            m_t++;
            m_tick = (m_t % TD == 0);
            m_lfsr = lfsr_next(m_lfsr);
        end
        e.p1 = {16'(m_x[0]), 16'(m_g[0])};
        e.p2 = {16'(m_x[1]), 16'(m_g[1])};
        e.p3 = {16'(m_x[2]), 16'(m_g[2])};
        e.ps = m_pass;
        e.tk = m_tick;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (pipe1 === e.p1 && pipe2 === e.p2 && pipe3 === e.p3 &&
                pass === e.ps && tick === e.tk) begin
                n_ok++;
            end else begin
                $display("FAIL model t=%0t: got %h %h %h p%b t%b, required %h %h %h p%b t%b",
                         $time, pipe1, pipe2, pipe3, pass, tick,
                         e.p1, e.p2, e.p3, e.ps, e.tk);
            end
        end
    end

    initial begin
        int k;
        int len;
        bit [1:0] s;
        play_ticks = 0;
        rst = 1'b1;
        status = 2'b00;

        cyc(1, 2'b00);
        check("reset_pipe1", pipe1, 32'h02B400B4);
        check("reset_pipe3_x", pipe3[31:16], 1172);
        for (int i = 0; i < 20; i++) cyc(0, 2'b00);
        check("ready_pipe2_x", pipe2[31:16], 932);

        play_ticks = 0;
        while (play_ticks < 350) begin
            k = play_ticks;
            cyc(0, 2'b01);
            if (play_ticks != k) begin
                if (play_ticks == 1) begin
                    check("tick1_p1x", pipe1[31:16], 690);
                    check("tick1_p2x", pipe2[31:16], 930);
                    check("tick1_p3x", pipe3[31:16], 1170);
                    check("tick1_gap", pipe1[15:0], 180);
                end
                if (play_ticks == 265) check("pass_265", pass, 0);
                if (play_ticks == 266) begin
                    check("pass_266_x", pipe1[31:16], 160);
                    check("pass_266", pass, 1);
                end
                if (play_ticks == 267) check("pass_267", pass, 0);
                if (play_ticks == 345) check("p1x_345", pipe1[31:16], 2);
                if (play_ticks == 346) begin
                    check("respawn_p1x", pipe1[31:16], 720);
                    check("respawn_p3x", pipe3[31:16], 480);
                    check("respawn_gap_range",
                          (pipe1[15:0] >= 40 && pipe1[15:0] <= 319), 1);
                end
            end else if (play_ticks == 266) begin
                check("pass_one_cycle", pass, 0);
            end
        end

        for (int i = 0; i < 50; i++) cyc(0, 2'b10);
        check("over_pass", pass, 0);
        cyc(0, 2'b00);
        check("ready_reload", pipe1, 32'h02B400B4);

        for (int i = 0; i < 37; i++) cyc(0, 2'b01);
        while (!m_tick) cyc(0, 2'b01);
        cyc(1, 2'b01);
        check("rst_tick_pipe1", pipe1, 32'h02B400B4);
        check("rst_tick_tick", tick, 0);

        for (int seg = 0; seg < 60; seg++) begin
            k = $urandom_range(0, 9);
            s = (k < 6) ? 2'b01 : (k < 7) ? 2'b00 : (k < 9) ? 2'b10 : 2'b11;
            len = $urandom_range(1, 400);
            for (int i = 0; i < len; i++) cyc(0, s);
            if ($urandom_range(0, 19) == 0) cyc(1, 2'(($urandom_range(0, 3))));
        end
        for (int i = 0; i < 3000; i++) cyc(0, 2'b01);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_ok, n_checks);
        $finish;
    end

endmodule
